// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg: opcode/reply bytes, reply lengths and FSM encodings for uart_cmd_bridge
package uart_bridge_pkg;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_BAD = 8'h3F;
  localparam logic [2:0] LEN_RD  = 3'd4;
  localparam logic [2:0] LEN_WR  = 3'd1;
  localparam logic [2:0] LEN_BAD = 3'd1;
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_BUS, ST_RESP} state_t;
  typedef enum logic [1:0] {SER_IDLE, SER_PULSE, SER_GAP, SER_WAIT} ser_t;
endpackage

// File: rtl/uart_cmd_bridge_if.sv
// uart_cmd_bridge_if: UART byte side, req/ack bus and busy flag of the command bridge
// master: the bridge (drives tx_*, bus_* requests, busy); slave: UART + bus + host side
interface uart_cmd_bridge_if #(parameter int AW = 16);
  logic rx_valid;
  logic [7:0] rx_byte;
  logic rx_error;
  logic tx_start;
  logic [7:0] tx_byte;
  logic tx_busy;
  logic bus_req;
  logic bus_we;
  logic [AW-1:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic bus_ack;
  logic busy;
  modport master (
    input rx_valid, rx_byte, rx_error, tx_busy, bus_rdata, bus_ack,
    output tx_start, tx_byte, bus_req, bus_we, bus_addr, bus_wdata, busy
  );
  modport slave (
    output rx_valid, rx_byte, rx_error, tx_busy, bus_rdata, bus_ack,
    input tx_start, tx_byte, bus_req, bus_we, bus_addr, bus_wdata, busy
  );
endinterface

// File: rtl/uart_resp_ser.sv
// uart_resp_ser: shifts out up to 4 reply bytes MSB first through the UART transmitter
// ports: clk, rst, load/data/len (start a reply, data left-aligned), tx_busy in,
//        tx_start/tx_byte out, done (1-cycle pulse as the last byte completes)
module uart_resp_ser
  import uart_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [2:0]  len,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  output logic        done
);
  ser_t state, next;
  logic [31:0] sh;
  logic [2:0] cnt;
  always_ff @(posedge clk)
    if (rst) begin
      state <= SER_IDLE;
      sh <= '0;
      cnt <= '0;
    end else begin
      state <= next;
      if (load) begin
        sh <= data;
        cnt <= len;
      end else if (state == SER_WAIT && !tx_busy) begin
        sh <= {sh[23:0], 8'h00};
        cnt <= cnt - 3'd1;
      end
    end
  // GAP skips one cycle because the UART raises tx_busy a cycle after tx_start
  always_comb begin
    next = state;
    tx_start = 1'b0;
    done = 1'b0;
    case (state)
      SER_IDLE: next = load ? SER_PULSE : SER_IDLE;
      SER_PULSE: begin
        tx_start = !tx_busy;
        next = tx_busy ? SER_PULSE : SER_GAP;
      end
      SER_GAP: next = SER_WAIT;
      SER_WAIT: begin
        done = !tx_busy && cnt == 3'd1;
        next = tx_busy ? SER_WAIT : (cnt == 3'd1 ? SER_IDLE : SER_PULSE);
      end
      default: next = SER_IDLE;
    endcase
  end
  assign tx_byte = sh[31:24];
endmodule

// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: parses 'R'/'W' UART command frames into single-word bus accesses and replies
// ports: clk, rst (sync, active-high), io (uart_cmd_bridge_if.master: rx/tx bytes, req/ack bus, busy)
// UART_BRIDGE_TIMEOUT_EN: when defined, a partial frame idle for TIMEOUT_CYC cycles is dropped
module uart_cmd_bridge
  import uart_bridge_pkg::*;
#(
  parameter int AW = 16,
  parameter int TIMEOUT_CYC = 2000000
) (
  input logic clk,
  input logic rst,
  uart_cmd_bridge_if.master io
);
  localparam int NB = AW / 8;
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end
  state_t state, next;
  logic [3:0] cnt;
  logic op_wr;
  logic [AW-1:0] addr;
  logic [31:0] wdata;
  logic take, tmo, load, done;
  logic [31:0] load_data;
  logic [2:0] load_len;
  assign take = io.rx_valid && !io.rx_error && (state == ST_ADDR || state == ST_DATA);
`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CYC);
  logic [GW-1:0] gap;
  logic in_frame;
  assign in_frame = state == ST_ADDR || state == ST_DATA;
  always_ff @(posedge clk)
    gap <= (rst || io.rx_valid || !in_frame) ? '0 : gap + GW'(1);
  assign tmo = in_frame && !io.rx_valid && gap == GW'(TIMEOUT_CYC - 1);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      op_wr <= 1'b0;
      addr <= '0;
      wdata <= '0;
    end else begin
      state <= next;
      cnt <= (next != state) ? '0 : cnt + 4'(take);
      if (state == ST_IDLE && io.rx_valid && !io.rx_error) op_wr <= io.rx_byte == OP_WR;
      if (take && state == ST_ADDR) addr <= AW'({addr, io.rx_byte});
      if (take && state == ST_DATA) wdata <= 32'({wdata, io.rx_byte});
    end
  // rx_error beats rx_valid everywhere a frame is being collected; BUS/RESP ignore rx entirely
  always_comb begin
    next = state;
    load = 1'b0;
    load_data = '0;
    load_len = '0;
    case (state)
      ST_IDLE:
        if (io.rx_valid && !io.rx_error) begin
          if (io.rx_byte == OP_RD || io.rx_byte == OP_WR) next = ST_ADDR;
          else begin
            next = ST_RESP;
            load = 1'b1;
            load_data = {RSP_BAD, 24'h0};
            load_len = LEN_BAD;
          end
        end
      ST_ADDR: next = (io.rx_error || tmo) ? ST_IDLE :
                      (take && cnt == 4'(NB - 1)) ? (op_wr ? ST_DATA : ST_BUS) : ST_ADDR;
      ST_DATA: next = (io.rx_error || tmo) ? ST_IDLE : (take && cnt == 4'd3) ? ST_BUS : ST_DATA;
      ST_BUS:
        if (io.bus_ack) begin
          next = ST_RESP;
          load = 1'b1;
          load_data = op_wr ? {RSP_OK, 24'h0} : io.bus_rdata;
          load_len = op_wr ? LEN_WR : LEN_RD;
        end
      ST_RESP: next = done ? ST_IDLE : ST_RESP;
      default: next = ST_IDLE;
    endcase
  end
  uart_resp_ser u_ser (
    .clk(clk),
    .rst(rst),
    .load(load),
    .data(load_data),
    .len(load_len),
    .tx_busy(io.tx_busy),
    .tx_start(io.tx_start),
    .tx_byte(io.tx_byte),
    .done(done)
  );
  assign io.bus_req = state == ST_BUS;
  assign io.bus_we = op_wr;
  assign io.bus_addr = addr;
  assign io.bus_wdata = wdata;
  assign io.busy = state != ST_IDLE;
endmodule
